// File: rtl/ddr_ui_responder.sv
// ddr_ui_responder: BRAM-backed stand-in for the DDR controller app_* port.
// In-order command execution, 2-beat lines, fixed read latency.
module ddr_ui_responder #(
  parameter int ADDR_BITS    = 27,
  parameter int MEM_LINES    = 1024,
  parameter int CALIB_CYCLES = 64,
  parameter int READ_LATENCY = 8,
  parameter int CMD_DEPTH    = 4,
  parameter int WDF_DEPTH    = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  output logic                 init_calib_complete_o,
  input  logic [ADDR_BITS-1:0] app_addr_i,
  input  logic [2:0]           app_cmd_i,
  input  logic                 app_en_i,
  output logic                 app_rdy_o,
  input  logic [63:0]          app_wdf_data_i,
  input  logic [7:0]           app_wdf_mask_i,
  input  logic                 app_wdf_end_i,
  input  logic                 app_wdf_wren_i,
  output logic                 app_wdf_rdy_o,
  output logic [63:0]          app_rd_data_o,
  output logic                 app_rd_data_valid_o,
  output logic                 app_rd_data_end_o,
  output logic                 cmd_error_o
);

  localparam int IDX = $clog2(MEM_LINES);
  localparam int CW  = 3 + IDX;
  localparam int WW  = 16 + 128;
  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int WAW = $clog2(WDF_DEPTH);
  localparam int CCW = $clog2(CALIB_CYCLES + 1);
  localparam int LW  = $clog2(READ_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RWAIT,
    S_BEAT0,
    S_BEAT1
  } state_t;

  state_t state_q;
  state_t state_n;

  logic           calib_q;
  logic [CCW-1:0] calib_cnt;

  logic [CW-1:0]  cmd_mem [CMD_DEPTH];
  logic [CAW-1:0] cmd_wp;
  logic [CAW-1:0] cmd_rp;
  logic [CAW:0]   cmd_cnt;
  logic           cmd_full;
  logic           cmd_empty;
  logic           cmd_push;
  logic           cmd_pop;
  logic [CW-1:0]  cmd_head;
  logic [2:0]     head_cmd;
  logic [IDX-1:0] head_idx;
  logic           head_wr;
  logic           head_rd;

  logic [WW-1:0]  wdf_mem [WDF_DEPTH];
  logic [WAW-1:0] wdf_wp;
  logic [WAW-1:0] wdf_rp;
  logic [WAW:0]   wdf_cnt;
  logic           wdf_full;
  logic           wdf_empty;
  logic           wdf_push;
  logic           wdf_pop;
  logic [WW-1:0]  wdf_din;
  logic [WW-1:0]  wdf_head;
  logic [15:0]    wdf_mask;
  logic [127:0]   wdf_data;

  logic           beat_acc;
  logic           half_q;
  logic [63:0]    lo_data_q;
  logic [7:0]     lo_mask_q;

  logic [127:0]   mem [MEM_LINES];
  logic [127:0]   rd_line;
  logic [IDX-1:0] rd_idx_q;
  logic [IDX-1:0] rd_addr;
  logic [LW-1:0]  lat_q;
  logic           mem_we;
  logic           rd_start;

  logic           valid_q;
  logic           end_q;
  logic [63:0]    data_q;
  logic           err_q;

  logic           unused_addr;

  assign unused_addr = ^{app_addr_i[ADDR_BITS-1:IDX+3],
                         app_addr_i[2:0]};

  assign init_calib_complete_o = calib_q;
  assign app_rdy_o     = calib_q && !cmd_full;
  assign app_wdf_rdy_o = calib_q && !wdf_full;
  assign app_rd_data_o       = data_q;
  assign app_rd_data_valid_o = valid_q;
  assign app_rd_data_end_o   = end_q;
  assign cmd_error_o         = err_q;

  assign cmd_full  = cmd_cnt == (CAW+1)'(CMD_DEPTH);
  assign cmd_empty = cmd_cnt == '0;
  assign cmd_push  = app_en_i && app_rdy_o;
  assign cmd_head  = cmd_mem[cmd_rp];
  assign head_cmd  = cmd_head[CW-1 -: 3];
  assign head_idx  = cmd_head[IDX-1:0];
  assign head_wr   = head_cmd == 3'b000;
  assign head_rd   = head_cmd == 3'b001;

  assign wdf_full  = wdf_cnt == (WAW+1)'(WDF_DEPTH);
  assign wdf_empty = wdf_cnt == '0;
  assign wdf_head  = wdf_mem[wdf_rp];
  assign wdf_mask  = wdf_head[WW-1 -: 16];
  assign wdf_data  = wdf_head[127:0];

  assign beat_acc = app_wdf_wren_i && app_wdf_rdy_o;
  assign wdf_push = beat_acc && (half_q || app_wdf_end_i);
  assign wdf_din  = half_q ?
    {app_wdf_mask_i, lo_mask_q, app_wdf_data_i, lo_data_q} :
    {8'hFF, app_wdf_mask_i, 64'd0, app_wdf_data_i};

  assign rd_addr = (state_q == S_IDLE) ? head_idx : rd_idx_q;

  // calibration counter, saturates once done
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      calib_cnt <= '0;
      calib_q   <= 1'b0;
    end else if (!calib_q) begin
      calib_cnt <= calib_cnt + 1'b1;
      calib_q   <= calib_cnt == CCW'(CALIB_CYCLES - 1);
    end
  end

  // command fifo pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cmd_wp  <= '0;
      cmd_rp  <= '0;
      cmd_cnt <= '0;
    end else begin
      if (cmd_push) cmd_wp <= cmd_wp + 1'b1;
      if (cmd_pop)  cmd_rp <= cmd_rp + 1'b1;
      if (cmd_push && !cmd_pop)
        cmd_cnt <= cmd_cnt + 1'b1;
      else if (!cmd_push && cmd_pop)
        cmd_cnt <= cmd_cnt - 1'b1;
    end
  end

  // command fifo storage: cmd code plus line index
  always_ff @(posedge clk_i) begin
    if (cmd_push)
      cmd_mem[cmd_wp] <= {app_cmd_i, app_addr_i[3 +: IDX]};
  end

  // write-line fifo pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wdf_wp  <= '0;
      wdf_rp  <= '0;
      wdf_cnt <= '0;
    end else begin
      if (wdf_push) wdf_wp <= wdf_wp + 1'b1;
      if (wdf_pop)  wdf_rp <= wdf_rp + 1'b1;
      if (wdf_push && !wdf_pop)
        wdf_cnt <= wdf_cnt + 1'b1;
      else if (!wdf_push && wdf_pop)
        wdf_cnt <= wdf_cnt - 1'b1;
    end
  end

  // write-line fifo storage: {mask, data}
  always_ff @(posedge clk_i) begin
    if (wdf_push) wdf_mem[wdf_wp] <= wdf_din;
  end

  // beat collector: holds the lower half until the line ends
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      half_q    <= 1'b0;
      lo_data_q <= '0;
      lo_mask_q <= '0;
    end else if (beat_acc) begin
      if (half_q) begin
        half_q <= 1'b0;
      end else if (!app_wdf_end_i) begin
        half_q    <= 1'b1;
        lo_data_q <= app_wdf_data_i;
        lo_mask_q <= app_wdf_mask_i;
      end
    end
  end

  // fsm state register plus read datapath registers
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      lat_q    <= '0;
      rd_idx_q <= '0;
      valid_q  <= 1'b0;
      end_q    <= 1'b0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      lat_q   <= (state_q == S_RWAIT) ? lat_q + 1'b1 : '0;
      if (rd_start) rd_idx_q <= head_idx;
      valid_q <= (state_n == S_BEAT0) || (state_n == S_BEAT1);
      end_q   <= state_n == S_BEAT1;
      unique case (state_n)
        S_BEAT0: data_q <= rd_line[63:0];
        S_BEAT1: data_q <= rd_line[127:64];
        default: data_q <= '0;
      endcase
      err_q <= cmd_push && (app_cmd_i[2:1] != 2'b00);
    end
  end

  // next-state logic
  always_comb begin
    state_n = state_q;
    unique case (state_q)
      S_IDLE:  if (rd_start) state_n = S_RWAIT;
      S_RWAIT: if (lat_q == LW'(READ_LATENCY - 1))
                 state_n = S_BEAT0;
      S_BEAT0: state_n = S_BEAT1;
      S_BEAT1: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // fsm outputs: fifo pops, bram commit, read start
  always_comb begin
    cmd_pop  = 1'b0;
    wdf_pop  = 1'b0;
    mem_we   = 1'b0;
    rd_start = 1'b0;
    if (state_q == S_IDLE && !cmd_empty) begin
      unique case (1'b1)
        head_wr: begin
          if (!wdf_empty) begin
            cmd_pop = 1'b1;
            wdf_pop = 1'b1;
            mem_we  = 1'b1;
          end
        end
        head_rd: begin
          cmd_pop  = 1'b1;
          rd_start = 1'b1;
        end
        default: cmd_pop = 1'b1;
      endcase
    end
  end

  // bram byte-masked write commit
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < 16; b++) begin
        if (!wdf_mask[b])
          mem[head_idx][8*b +: 8] <= wdf_data[8*b +: 8];
      end
    end
  end

  // bram read; line held stable while beats go out
  always_ff @(posedge clk_i) begin
    if (state_q == S_IDLE || state_q == S_RWAIT)
      rd_line <= mem[rd_addr];
  end

endmodule

// File: tb/tb_ddr_ui_responder.sv
// tb_ddr_ui_responder: directed plus random stimulus against an
// order-based memory model with byte masks.
module tb_ddr_ui_responder;

  localparam int CAL = 64;
  localparam int LAT = 8;
  localparam int DEP = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        calib;
  logic [26:0] app_addr;
  logic [2:0]  app_cmd;
  logic        app_en;
  logic        app_rdy;
  logic [63:0] wdata;
  logic [7:0]  wmask;
  logic        wend;
  logic        wren;
  logic        wdf_rdy;
  logic [63:0] rd_data;
  logic        rd_valid;
  logic        rd_end;
  logic        cmd_err;

  int checks = 0;
  int errors = 0;
  longint cyc = 0;
  longint last_b0_cyc = 0;
  longint acc;
  logic idle_bad = 1'b0;
  int stall_cnt = 0;

  logic [127:0] mdl [int];
  logic [64:0]  exp_q [$];
  logic [64:0]  got_q [$];
  logic [143:0] line_q [$];
  logic [2:0]   mc_cmd [$];
  int           mc_idx [$];
  logic         m_half = 1'b0;
  logic [63:0]  m_lo;
  logic [7:0]   m_lom;

  always #5 clk = ~clk;

  ddr_ui_responder dut (
    .clk_i                 (clk),
    .rst_n_i               (rst_n),
    .init_calib_complete_o (calib),
    .app_addr_i            (app_addr),
    .app_cmd_i             (app_cmd),
    .app_en_i              (app_en),
    .app_rdy_o             (app_rdy),
    .app_wdf_data_i        (wdata),
    .app_wdf_mask_i        (wmask),
    .app_wdf_end_i         (wend),
    .app_wdf_wren_i        (wren),
    .app_wdf_rdy_o         (wdf_rdy),
    .app_rd_data_o         (rd_data),
    .app_rd_data_valid_o   (rd_valid),
    .app_rd_data_end_o     (rd_end),
    .cmd_error_o           (cmd_err)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      got_q.push_back({rd_end, rd_data});
      if (rd_end === 1'b0) last_b0_cyc <= cyc;
    end else if (rd_valid === 1'b0) begin
      if (rd_data !== 64'd0 || rd_end !== 1'b0)
        idle_bad <= 1'b1;
    end
  end

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, req);
    end
  endtask

  // model: commands execute strictly in issue order; a write
  // needs the next collected line, reads snapshot the memory
  function automatic void m_run();
    logic [127:0] ln;
    logic [143:0] wl;
    while (mc_cmd.size() > 0) begin
      if (mc_cmd[0] == 3'b000) begin
        if (line_q.size() == 0) break;
        wl = line_q.pop_front();
        ln = mdl.exists(mc_idx[0]) ? mdl[mc_idx[0]] : 'x;
        for (int b = 0; b < 16; b++)
          if (!wl[128 + b]) ln[8*b +: 8] = wl[8*b +: 8];
        mdl[mc_idx[0]] = ln;
      end else if (mc_cmd[0] == 3'b001) begin
        ln = mdl.exists(mc_idx[0]) ? mdl[mc_idx[0]] : 'x;
        exp_q.push_back({1'b0, ln[63:0]});
        exp_q.push_back({1'b1, ln[127:64]});
      end
      void'(mc_cmd.pop_front());
      void'(mc_idx.pop_front());
    end
  endfunction

  function automatic void m_beat(input logic [63:0] d,
                                 input logic [7:0] m,
                                 input logic e);
    if (m_half) begin
      line_q.push_back({m, m_lom, d, m_lo});
      m_half = 1'b0;
    end else if (e) begin
      line_q.push_back({8'hFF, m, 64'd0, d});
    end else begin
      m_half = 1'b1;
      m_lo = d;
      m_lom = m;
    end
    m_run();
  endfunction

  function automatic void m_reset();
    mc_cmd.delete();
    mc_idx.delete();
    line_q.delete();
    m_half = 1'b0;
  endfunction

  task automatic cmd(input logic [2:0] c,
                     input logic [26:0] a,
                     output longint at);
    int n = 0;
    app_en = 1'b1;
    app_cmd = c;
    app_addr = a;
    while (app_rdy !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
      stall_cnt++;
    end
    checks++;
    assert (n < 300) else begin
      errors++;
      $error("FAIL cmd_timeout observed %0d expected <300", n);
    end
    at = cyc + 1;
    @(negedge clk);
    mc_cmd.push_back(c);
    mc_idx.push_back(int'(a[12:3]));
    m_run();
  endtask

  task automatic beat(input logic [63:0] d,
                      input logic [7:0] m,
                      input logic e);
    int n = 0;
    wren = 1'b1;
    wdata = d;
    wmask = m;
    wend = e;
    while (wdf_rdy !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (n < 300) else begin
      errors++;
      $error("FAIL beat_timeout observed %0d expected <300", n);
    end
    @(negedge clk);
    m_beat(d, m, e);
  endtask

  task automatic wr_line(input logic [63:0] lo, hi,
                         input logic [7:0] ml, mh);
    beat(lo, ml, 1'b0);
    beat(hi, mh, 1'b1);
    wren = 1'b0;
  endtask

  task automatic wr(input logic [26:0] a,
                    input logic [63:0] lo, hi,
                    input logic [7:0] ml, mh);
    longint t;
    cmd(3'b000, a, t);
    app_en = 1'b0;
    wr_line(lo, hi, ml, mh);
  endtask

  task automatic rd(input logic [26:0] a);
    longint t;
    cmd(3'b001, a, t);
    app_en = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    int k;
    while (got_q.size() < exp_q.size() && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk({tag, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
    k = 0;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      chk($sformatf("%s_beat%0d", tag, k),
          128'(got_q.pop_front()), 128'(exp_q.pop_front()));
      k++;
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic calib_seq(input string tag);
    repeat (CAL - 1) @(negedge clk);
    chk({tag, "_calib_early"}, 128'(calib), 128'(0));
    chk({tag, "_rdy_early"}, 128'({app_rdy, wdf_rdy}), 128'(0));
    @(negedge clk);
    chk({tag, "_calib"}, 128'(calib), 128'(1));
    chk({tag, "_rdy"}, 128'({app_rdy, wdf_rdy}), 128'(3));
  endtask

  initial begin
    logic [26:0] a;
    logic [63:0] lo, hi;
    logic [7:0]  ml, mh;
    logic [26:0] addrs [5];
    int n;
    int idx;

    rst_n = 1'b0;
    app_addr = '0;
    app_cmd = '0;
    app_en = 1'b0;
    wdata = '0;
    wmask = '0;
    wend = 1'b0;
    wren = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_outs",
        128'({calib, app_rdy, wdf_rdy, rd_valid, rd_end, cmd_err}),
        128'(0));
    chk("reset_data", 128'(rd_data), 128'(0));
    rst_n = 1'b1;
    calib_seq("t1");

    wr(27'h40, 64'h1111111111111111, 64'h2222222222222222,
       8'h00, 8'h00);
    repeat (4) @(negedge clk);
    cmd(3'b001, 27'h40, acc);
    app_en = 1'b0;
    drain("t2");
    chk("t2_latency", 128'(last_b0_cyc), 128'(acc + 1 + LAT));

    wr(27'h80, '1, '1, 8'h00, 8'h00);
    wr(27'h80, '0, '0, 8'h0F, 8'h0F);
    rd(27'h80);
    drain("t3");

    addrs[0] = 27'h200;
    addrs[1] = 27'h1308;
    addrs[2] = 27'h7ff8;
    addrs[3] = 27'h40;
    addrs[4] = 27'h80;
    for (int i = 0; i < 3; i++)
      wr_line({$urandom, $urandom}, {$urandom, $urandom},
              8'h00, 8'h00);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      cmd(3'b000, addrs[i], acc);
      app_en = 1'b0;
    end
    for (int i = 0; i < 3; i++) rd(addrs[i]);
    drain("t4");

    stall_cnt = 0;
    for (int i = 0; i < DEP + 2; i++)
      cmd(3'b001, addrs[i % 5], acc);
    app_en = 1'b0;
    chk("t5_rdy_drop", 128'(stall_cnt > 0), 128'(1));
    drain("t5");

    wr(27'h500, {$urandom, $urandom}, {$urandom, $urandom},
       8'h00, 8'h00);
    cmd(3'b000, 27'h500, acc);
    app_en = 1'b0;
    beat(64'hA5A5A5A5_5A5A5A5A, 8'h00, 1'b1);
    wren = 1'b0;
    cmd(3'b000, 27'h600, acc);
    app_en = 1'b0;
    beat({$urandom, $urandom}, 8'h00, 1'b0);
    beat({$urandom, $urandom}, 8'h00, 1'b0);
    wren = 1'b0;
    wr(27'h608, {$urandom, $urandom}, {$urandom, $urandom},
       8'h00, 8'h00);
    rd(27'h500);
    rd(27'h600);
    rd(27'h608);
    drain("edge_end");

    for (int i = 0; i < 8; i++)
      wr({14'($urandom), 10'(300 + i), 3'($urandom)},
         {$urandom, $urandom}, {$urandom, $urandom},
         8'h00, 8'h00);
    for (int k = 0; k < 30; k++) begin
      idx = 300 + int'($urandom_range(0, 7));
      a = {14'($urandom), 10'(idx), 3'($urandom)};
      if ($urandom_range(0, 9) < 6) begin
        lo = {$urandom, $urandom};
        hi = {$urandom, $urandom};
        ml = 8'($urandom);
        mh = 8'($urandom);
        if ($urandom_range(0, 1) == 1) begin
          cmd(3'b000, a, acc);
          app_en = 1'b0;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          wr_line(lo, hi, ml, mh);
        end else begin
          wr_line(lo, hi, ml, mh);
          repeat ($urandom_range(0, 3)) @(negedge clk);
          cmd(3'b000, a, acc);
          app_en = 1'b0;
        end
      end else begin
        rd(a);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain("rand");

    rd(27'h40);
    n = 0;
    while (rd_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t6_beat0_seen", 128'(n < 100), 128'(1));
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_valid_drop", 128'({rd_valid, rd_end}), 128'(0));
    chk("t6_calib_drop", 128'({calib, app_rdy}), 128'(0));
    got_q.delete();
    exp_q.delete();
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    calib_seq("t6");
    cmd(3'b111, 27'h40, acc);
    app_en = 1'b0;
    chk("t6_err_pulse", 128'(cmd_err), 128'(1));
    @(negedge clk);
    chk("t6_err_clear", 128'(cmd_err), 128'(0));
    repeat (30) @(negedge clk);
    chk("t6_no_data", 128'(got_q.size()), 128'(0));
    rd(27'h40);
    drain("t6_after");

    chk("idle_data_zero", 128'(idle_bad), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
